div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 21 ++
 rtl/div_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative integer divider: op encodings, FSM states
// and the fixed iteration count of the radix-2 datapath.
package div_unit_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned DIV_ITERS = 32;
  localparam logic [5:0]  DIV_LAST  = 6'(DIV_ITERS - 1);

endpackage

// File: rtl/div_unit.sv
// 32-bit radix-2 restoring divider for DIV/DIVU/REM/REMU: 32 CALC cycles, done one
// cycle later; divide-by-zero and signed overflow finish at T+1. No start while busy.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic        neg_q;
  logic        neg_r;
  logic        sel_rem;

  op_t         op_in;
  logic        is_signed;
  logic        is_rem;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        div_zero;
  logic        sgn_ovf;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] q_fin;
  logic [31:0] r_fin;

  assign op_in = op_t'(op);

  always_comb begin
    is_signed = (op_in == OP_DIV) || (op_in == OP_REM);
    is_rem    = (op_in == OP_REM) || (op_in == OP_REMU);
    a_neg     = is_signed & dividend[31];
    b_neg     = is_signed & divisor[31];
    a_mag     = a_neg ? (32'd0 - dividend) : dividend;
    b_mag     = b_neg ? (32'd0 - divisor)  : divisor;
    div_zero  = (divisor == 32'd0);
    sgn_ovf   = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
  end

  // One restoring step: the dividend magnitude shifts out of quo_q into the
  // partial remainder while quotient bits shift in from the bottom.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[32]) begin
      rem_nxt = diff[31:0];
      quo_nxt = {quo_q[30:0], 1'b1};
    end else begin
      rem_nxt = shifted[31:0];
      quo_nxt = {quo_q[30:0], 1'b0};
    end
    q_fin = neg_q ? (32'd0 - quo_nxt) : quo_nxt;
    r_fin = neg_r ? (32'd0 - rem_nxt) : rem_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= 32'd0;
      cnt     <= 6'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      sel_rem <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= 6'd0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sel_rem <= is_rem;
            cnt     <= 6'd0;
            busy    <= 1'b1;
            if (div_zero) begin
              result <= is_rem ? dividend : 32'hFFFF_FFFF;
              state  <= S_DONE;
              done   <= 1'b1;
            end else if (sgn_ovf) begin
              result <= is_rem ? 32'd0 : 32'h8000_0000;
              state  <= S_DONE;
              done   <= 1'b1;
            end else begin
              quo_q <= a_mag;
              rem_q <= 32'd0;
              dvs_q <= b_mag;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt + 6'd1;
          if (cnt == DIV_LAST) begin
            state  <= S_DONE;
            done   <= 1'b1;
            result <= sel_rem ? r_fin : q_fin;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          cnt   <= 6'd0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
